time_set: RTL and testbench

TIME_SET -- requirements
Module: time_set

---
 rtl/time_pkg.sv | 86 ++++++++
 rtl/time_field_step.sv | 34 +++
 rtl/time_set.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_time_set.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_pkg.sv
// Shared definitions for the time/date/alarm setting block: field widths,
// packing bit positions, field limits, FIELD_SEL encodings, FSM states and
// small helper functions used by time_set.
package time_pkg;

    // Field widths
    localparam int HOUR_W  = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;
    localparam int YEAR_W  = 7;
    localparam int MONTH_W = 4;
    localparam int DAY_W   = 5;
    localparam int STEP_W  = 7;   // wide enough for any single field

    // Packing of {MERIDIAN, HOUR, MIN, SEC} (alarm uses the same without MERIDIAN)
    localparam int TIME_SEC_LSB  = 0;
    localparam int TIME_MIN_LSB  = 6;
    localparam int TIME_HOUR_LSB = 12;
    localparam int TIME_MER_BIT  = 17;

    // Packing of {YEAR, MONTH, DAY}
    localparam int DATE_DAY_LSB   = 0;
    localparam int DATE_MONTH_LSB = 5;
    localparam int DATE_YEAR_LSB  = 9;

    // Field limits
    localparam logic [STEP_W-1:0] HOUR_MIN  = 7'd0;
    localparam logic [STEP_W-1:0] HOUR_MAX  = 7'd23;
    localparam logic [STEP_W-1:0] MIN_MIN   = 7'd0;
    localparam logic [STEP_W-1:0] MIN_MAX   = 7'd59;
    localparam logic [STEP_W-1:0] SEC_MIN   = 7'd0;
    localparam logic [STEP_W-1:0] SEC_MAX   = 7'd59;
    localparam logic [STEP_W-1:0] YEAR_MIN  = 7'd0;
    localparam logic [STEP_W-1:0] YEAR_MAX  = 7'd99;
    localparam logic [STEP_W-1:0] MONTH_MIN = 7'd1;
    localparam logic [STEP_W-1:0] MONTH_MAX = 7'd12;
    localparam logic [STEP_W-1:0] DAY_MIN   = 7'd1;
    localparam logic [STEP_W-1:0] DAY_MAX   = 7'd31;

    // Date value after reset: year 16, January 1st
    localparam logic [YEAR_W-1:0]  RST_YEAR  = 7'd16;
    localparam logic [MONTH_W-1:0] RST_MONTH = 4'd1;
    localparam logic [DAY_W-1:0]   RST_DAY   = 5'd1;

    // FIELD_SEL encodings
    localparam logic [2:0] FLD_HOUR  = 3'd0;
    localparam logic [2:0] FLD_MIN   = 3'd1;
    localparam logic [2:0] FLD_SEC   = 3'd2;
    localparam logic [2:0] FLD_YEAR  = 3'd3;
    localparam logic [2:0] FLD_MONTH = 3'd4;
    localparam logic [2:0] FLD_DAY   = 3'd5;

    // Setting FSM states
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_EDIT_TIME  = 2'd1,
        ST_EDIT_ALARM = 2'd2,
        ST_COMMIT     = 2'd3
    } state_e;

    // Returns v when it lies within [lo, hi], otherwise lo
    function automatic logic [STEP_W-1:0] fit_range(input logic [STEP_W-1:0] v,
                                                    input logic [STEP_W-1:0] lo,
                                                    input logic [STEP_W-1:0] hi);
        logic [STEP_W-1:0] r;
        if ((v < lo) || (v > hi)) begin
            r = lo;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Number of days in a month; February has 29 days when the two-digit year is a multiple of 4
    function automatic logic [DAY_W-1:0] month_len(input logic [MONTH_W-1:0] month,
                                                   input logic [YEAR_W-1:0]  year);
        logic [DAY_W-1:0] len;
        case (month)
            4'd2:                    len = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
            default:                 len = 5'd31;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/time_field_step.sv
// Single-field up/down stepper with wrap-around between min and max.
// Up has priority over down when both are asserted.
module time_field_step #(
    parameter int W = 7
) (
    input  logic [W-1:0] value_i,
    input  logic [W-1:0] min_i,
    input  logic [W-1:0] max_i,
    input  logic         up_i,
    input  logic         down_i,
    output logic [W-1:0] next_o
);

    // Next field value: increment/decrement with wrap at the limits
    always_comb begin
        next_o = value_i;
        if (up_i) begin
            if (value_i >= max_i) begin
                next_o = min_i;
            end else begin
                next_o = value_i + W'(1);
            end
        end else if (down_i) begin
            if (value_i <= min_i) begin
                next_o = max_i;
            end else begin
                next_o = value_i - W'(1);
            end
        end else begin
            next_o = value_i;
        end
    end

endmodule

// File: rtl/time_set.sv
// Button-driven editor for the running time/date and the alarm time.
// MODE cycles IDLE -> EDIT_TIME -> EDIT_ALARM -> IDLE, NEXT walks the fields
// and commits after the last one, UP/DOWN step the selected field.
// Optional build macro TIME_SET_MONTH_LEN_EN: limit DAY to the real month
// length (leap February when YEAR%4==0) and clamp DAY on MONTH/YEAR changes.
module time_set
    import time_pkg::*;
#(
    parameter int BLINK_DIV = 500
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        BTN_MODE,
    input  logic        BTN_NEXT,
    input  logic        BTN_UP,
    input  logic        BTN_DOWN,
    input  logic [17:0] CUR_TIME,
    input  logic [15:0] CUR_DATE,
    input  logic [16:0] CUR_ALARM,
    output logic [17:0] SET_TIME,
    output logic [15:0] SET_DATE,
    output logic [16:0] SET_ALARM,
    output logic        SETTING,
    output logic        ALARM_SET,
    output logic        EDIT_ACTIVE,
    output logic [2:0]  FIELD_SEL,
    output logic        BLINK
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);

    state_e               state_q, state_d;
    logic [2:0]           fsel_q, fsel_d;
    logic [HOUR_W-1:0]    hour_q, hour_d;
    logic [MIN_W-1:0]     min_q, min_d;
    logic [SEC_W-1:0]     sec_q, sec_d;
    logic [YEAR_W-1:0]    year_q, year_d;
    logic [MONTH_W-1:0]   month_q, month_d;
    logic [DAY_W-1:0]     day_q, day_d;
    logic [HOUR_W-1:0]    al_hour_q, al_hour_d;
    logic [MIN_W-1:0]     al_min_q, al_min_d;
    logic [SEC_W-1:0]     al_sec_q, al_sec_d;
    logic                 setting_q, setting_d;
    logic                 alarm_set_q, alarm_set_d;
    logic                 edit_active_q, edit_active_d;
    logic                 blink_q, blink_d;
    logic [CNT_W-1:0]     bcnt_q, bcnt_d;

    logic                 ld_time_s, ld_alarm_s;
    logic [STEP_W-1:0]    step_val_s, step_min_s, step_max_s, step_next_s;
    logic                 step_up_s, step_down_s, step_en_s;
    logic [STEP_W-1:0]    day_max_s, ld_day_max_s;
    logic [STEP_W-1:0]    ld_hour_s, ld_min_s, ld_sec_s, ld_year_s, ld_month_s, ld_day_s;
    logic [STEP_W-1:0]    ld_al_hour_s, ld_al_min_s, ld_al_sec_s;
    logic                 cur_meridian_unused_s;

    // The incoming meridian bit is redundant; it is recomputed from HOUR
    assign cur_meridian_unused_s = CUR_TIME[TIME_MER_BIT];

    // Snapshot fields, forced to the field minimum when out of range
    assign ld_hour_s  = fit_range(STEP_W'(CUR_TIME[TIME_HOUR_LSB +: HOUR_W]), HOUR_MIN, HOUR_MAX);
    assign ld_min_s   = fit_range(STEP_W'(CUR_TIME[TIME_MIN_LSB +: MIN_W]), MIN_MIN, MIN_MAX);
    assign ld_sec_s   = fit_range(STEP_W'(CUR_TIME[TIME_SEC_LSB +: SEC_W]), SEC_MIN, SEC_MAX);
    assign ld_year_s  = fit_range(STEP_W'(CUR_DATE[DATE_YEAR_LSB +: YEAR_W]), YEAR_MIN, YEAR_MAX);
    assign ld_month_s = fit_range(STEP_W'(CUR_DATE[DATE_MONTH_LSB +: MONTH_W]), MONTH_MIN, MONTH_MAX);
    assign ld_day_s   = fit_range(STEP_W'(CUR_DATE[DATE_DAY_LSB +: DAY_W]), DAY_MIN, ld_day_max_s);
    assign ld_al_hour_s = fit_range(STEP_W'(CUR_ALARM[TIME_HOUR_LSB +: HOUR_W]), HOUR_MIN, HOUR_MAX);
    assign ld_al_min_s  = fit_range(STEP_W'(CUR_ALARM[TIME_MIN_LSB +: MIN_W]), MIN_MIN, MIN_MAX);
    assign ld_al_sec_s  = fit_range(STEP_W'(CUR_ALARM[TIME_SEC_LSB +: SEC_W]), SEC_MIN, SEC_MAX);

`ifdef TIME_SET_MONTH_LEN_EN
    assign ld_day_max_s = STEP_W'(month_len(ld_month_s[MONTH_W-1:0], ld_year_s[YEAR_W-1:0]));
    assign day_max_s    = STEP_W'(month_len(month_q, year_q));
`else
    assign ld_day_max_s = DAY_MAX;
    assign day_max_s    = DAY_MAX;
`endif

    // Only one button acts per cycle: UP wins over DOWN
    assign step_up_s   = BTN_UP;
    assign step_down_s = BTN_DOWN & ~BTN_UP;
    assign step_en_s   = BTN_UP | BTN_DOWN;

    // Route the selected field and its limits into the stepper
    always_comb begin
        step_val_s = 7'd0;
        step_min_s = 7'd0;
        step_max_s = 7'd0;
        if (state_q == ST_EDIT_ALARM) begin
            case (fsel_q)
                FLD_HOUR: begin step_val_s = STEP_W'(al_hour_q); step_min_s = HOUR_MIN; step_max_s = HOUR_MAX; end
                FLD_MIN:  begin step_val_s = STEP_W'(al_min_q);  step_min_s = MIN_MIN;  step_max_s = MIN_MAX;  end
                FLD_SEC:  begin step_val_s = STEP_W'(al_sec_q);  step_min_s = SEC_MIN;  step_max_s = SEC_MAX;  end
                default:  begin step_val_s = 7'd0; step_min_s = 7'd0; step_max_s = 7'd0; end
            endcase
        end else begin
            case (fsel_q)
                FLD_HOUR:  begin step_val_s = STEP_W'(hour_q);  step_min_s = HOUR_MIN;  step_max_s = HOUR_MAX;  end
                FLD_MIN:   begin step_val_s = STEP_W'(min_q);   step_min_s = MIN_MIN;   step_max_s = MIN_MAX;   end
                FLD_SEC:   begin step_val_s = STEP_W'(sec_q);   step_min_s = SEC_MIN;   step_max_s = SEC_MAX;   end
                FLD_YEAR:  begin step_val_s = STEP_W'(year_q);  step_min_s = YEAR_MIN;  step_max_s = YEAR_MAX;  end
                FLD_MONTH: begin step_val_s = STEP_W'(month_q); step_min_s = MONTH_MIN; step_max_s = MONTH_MAX; end
                FLD_DAY:   begin step_val_s = STEP_W'(day_q);   step_min_s = DAY_MIN;   step_max_s = day_max_s; end
                default:   begin step_val_s = 7'd0; step_min_s = 7'd0; step_max_s = 7'd0; end
            endcase
        end
    end

    time_field_step #(.W(STEP_W)) u_step (
        .value_i (step_val_s),
        .min_i   (step_min_s),
        .max_i   (step_max_s),
        .up_i    (step_up_s),
        .down_i  (step_down_s),
        .next_o  (step_next_s)
    );

    // Next state, field selection, edit registers and commit strobes
    always_comb begin
        state_d     = state_q;
        fsel_d      = fsel_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        year_d      = year_q;
        month_d     = month_q;
        day_d       = day_q;
        al_hour_d   = al_hour_q;
        al_min_d    = al_min_q;
        al_sec_d    = al_sec_q;
        setting_d   = 1'b0;
        alarm_set_d = 1'b0;
        ld_time_s   = 1'b0;
        ld_alarm_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (BTN_MODE) begin
                    state_d   = ST_EDIT_TIME;
                    fsel_d    = FLD_HOUR;
                    ld_time_s = 1'b1;
                end else begin
                    fsel_d = FLD_HOUR;
                end
            end
            ST_EDIT_TIME: begin
                if (BTN_MODE) begin
                    // Leaving time edit throws the edits away and restores the snapshot
                    state_d    = ST_EDIT_ALARM;
                    fsel_d     = FLD_HOUR;
                    ld_time_s  = 1'b1;
                    ld_alarm_s = 1'b1;
                end else if (BTN_NEXT) begin
                    if (fsel_q == FLD_DAY) begin
                        state_d   = ST_COMMIT;
                        setting_d = 1'b1;
                        fsel_d    = FLD_HOUR;
                    end else begin
                        fsel_d = fsel_q + 3'd1;
                    end
                end else if (step_en_s) begin
                    case (fsel_q)
                        FLD_HOUR:  hour_d  = step_next_s[HOUR_W-1:0];
                        FLD_MIN:   min_d   = step_next_s[MIN_W-1:0];
                        FLD_SEC:   sec_d   = step_next_s[SEC_W-1:0];
                        FLD_YEAR:  year_d  = step_next_s[YEAR_W-1:0];
                        FLD_MONTH: month_d = step_next_s[MONTH_W-1:0];
                        FLD_DAY:   day_d   = step_next_s[DAY_W-1:0];
                        default:   hour_d  = hour_q;
                    endcase
`ifdef TIME_SET_MONTH_LEN_EN
                    // A shorter month pulls DAY down to the new last day
                    if (((fsel_q == FLD_YEAR) || (fsel_q == FLD_MONTH)) &&
                        (day_d > month_len(month_d, year_d))) begin
                        day_d = month_len(month_d, year_d);
                    end else begin
                        day_d = day_d;
                    end
`endif
                end else begin
                    state_d = state_q;
                end
            end
            ST_EDIT_ALARM: begin
                if (BTN_MODE) begin
                    state_d = ST_IDLE;
                    fsel_d  = FLD_HOUR;
                end else if (BTN_NEXT) begin
                    if (fsel_q == FLD_SEC) begin
                        state_d     = ST_COMMIT;
                        alarm_set_d = 1'b1;
                        fsel_d      = FLD_HOUR;
                    end else begin
                        fsel_d = fsel_q + 3'd1;
                    end
                end else if (step_en_s) begin
                    case (fsel_q)
                        FLD_HOUR: al_hour_d = step_next_s[HOUR_W-1:0];
                        FLD_MIN:  al_min_d  = step_next_s[MIN_W-1:0];
                        FLD_SEC:  al_sec_d  = step_next_s[SEC_W-1:0];
                        default:  al_hour_d = al_hour_q;
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            ST_COMMIT: begin
                // Strobe cycle; buttons are ignored here
                state_d = ST_IDLE;
                fsel_d  = FLD_HOUR;
            end
            default: begin
                state_d = ST_IDLE;
                fsel_d  = FLD_HOUR;
            end
        endcase

        if (ld_time_s) begin
            hour_d  = ld_hour_s[HOUR_W-1:0];
            min_d   = ld_min_s[MIN_W-1:0];
            sec_d   = ld_sec_s[SEC_W-1:0];
            year_d  = ld_year_s[YEAR_W-1:0];
            month_d = ld_month_s[MONTH_W-1:0];
            day_d   = ld_day_s[DAY_W-1:0];
        end else begin
            hour_d = hour_d;
        end

        if (ld_alarm_s) begin
            al_hour_d = ld_al_hour_s[HOUR_W-1:0];
            al_min_d  = ld_al_min_s[MIN_W-1:0];
            al_sec_d  = ld_al_sec_s[SEC_W-1:0];
        end else begin
            al_hour_d = al_hour_d;
        end
    end

    // Edit indicator and blink divider; both idle at 0 outside the edit states
    always_comb begin
        edit_active_d = (state_d == ST_EDIT_TIME) || (state_d == ST_EDIT_ALARM);
        bcnt_d        = bcnt_q;
        blink_d       = blink_q;
        if (edit_active_d) begin
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d  = {CNT_W{1'b0}};
                blink_d = ~blink_q;
            end else begin
                bcnt_d  = bcnt_q + CNT_W'(1);
                blink_d = blink_q;
            end
        end else begin
            bcnt_d  = {CNT_W{1'b0}};
            blink_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q       <= ST_IDLE;
            fsel_q        <= FLD_HOUR;
            hour_q        <= 5'd0;
            min_q         <= 6'd0;
            sec_q         <= 6'd0;
            year_q        <= RST_YEAR;
            month_q       <= RST_MONTH;
            day_q         <= RST_DAY;
            al_hour_q     <= 5'd0;
            al_min_q      <= 6'd0;
            al_sec_q      <= 6'd0;
            setting_q     <= 1'b0;
            alarm_set_q   <= 1'b0;
            edit_active_q <= 1'b0;
            blink_q       <= 1'b0;
            bcnt_q        <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            fsel_q        <= fsel_d;
            hour_q        <= hour_d;
            min_q         <= min_d;
            sec_q         <= sec_d;
            year_q        <= year_d;
            month_q       <= month_d;
            day_q         <= day_d;
            al_hour_q     <= al_hour_d;
            al_min_q      <= al_min_d;
            al_sec_q      <= al_sec_d;
            setting_q     <= setting_d;
            alarm_set_q   <= alarm_set_d;
            edit_active_q <= edit_active_d;
            blink_q       <= blink_d;
            bcnt_q        <= bcnt_d;
        end
    end

    assign SET_TIME    = {(hour_q >= 5'd12), hour_q, min_q, sec_q};
    assign SET_DATE    = {year_q, month_q, day_q};
    assign SET_ALARM   = {al_hour_q, al_min_q, al_sec_q};
    assign SETTING     = setting_q;
    assign ALARM_SET   = alarm_set_q;
    assign EDIT_ACTIVE = edit_active_q;
    assign FIELD_SEL   = fsel_q;
    assign BLINK       = blink_q;

endmodule

// File: tb/tb_time_set.sv
// Testbench for time_set: directed scenarios followed by random button
// traffic, every cycle compared against a field-array reference model.
module tb_time_set;

    localparam int DIV = 5;
    localparam int M_IDLE = 0, M_TIME = 1, M_ALARM = 2, M_COMMIT = 3;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        BTN_MODE = 1'b0, BTN_NEXT = 1'b0, BTN_UP = 1'b0, BTN_DOWN = 1'b0;
    logic [17:0] CUR_TIME = 18'd0;
    logic [15:0] CUR_DATE = 16'd0;
    logic [16:0] CUR_ALARM = 17'd0;
    logic [17:0] SET_TIME;
    logic [15:0] SET_DATE;
    logic [16:0] SET_ALARM;
    logic        SETTING, ALARM_SET, EDIT_ACTIVE, BLINK;
    logic [2:0]  FIELD_SEL;

    time_set #(.BLINK_DIV(DIV)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .BTN_MODE(BTN_MODE), .BTN_NEXT(BTN_NEXT), .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN),
        .CUR_TIME(CUR_TIME), .CUR_DATE(CUR_DATE), .CUR_ALARM(CUR_ALARM),
        .SET_TIME(SET_TIME), .SET_DATE(SET_DATE), .SET_ALARM(SET_ALARM),
        .SETTING(SETTING), .ALARM_SET(ALARM_SET), .EDIT_ACTIVE(EDIT_ACTIVE),
        .FIELD_SEL(FIELD_SEL), .BLINK(BLINK)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Reference model: tf = {hour, min, sec, year, month, day}, al = {hour, min, sec}
    int mode = M_IDLE;
    int sel = 0;
    int tf[6];
    int al[3];
    int bcnt = 0;
    int e_blink = 0, e_setting = 0, e_aset = 0;

    function automatic int mlen(input int m, input int y);
        case (m)
            2:           return (y % 4 == 0) ? 29 : 28;
            4, 6, 9, 11: return 30;
            default:     return 31;
        endcase
    endfunction

    function automatic int day_limit();
`ifdef TIME_SET_MONTH_LEN_EN
        return mlen(tf[4], tf[3]);
`else
        return 31;
`endif
    endfunction

    function automatic int lo_of(input int f);
        return (f >= 4) ? 1 : 0;
    endfunction

    function automatic int hi_of(input int f);
        case (f)
            0:       return 23;
            1, 2:    return 59;
            3:       return 99;
            4:       return 12;
            default: return day_limit();
        endcase
    endfunction

    function automatic int wrap(input int v, input int lo, input int hi, input int dir);
        int span;
        span = hi - lo + 1;
        return ((v - lo + dir + span) % span) + lo;
    endfunction

    function automatic int fit(input int v, input int lo, input int hi);
        return (v < lo || v > hi) ? lo : v;
    endfunction

    task automatic load_time();
        tf[0] = fit((CUR_TIME >> 12) & 31, 0, 23);
        tf[1] = fit((CUR_TIME >> 6) & 63, 0, 59);
        tf[2] = fit(CUR_TIME & 63, 0, 59);
        tf[3] = fit((CUR_DATE >> 9) & 127, 0, 99);
        tf[4] = fit((CUR_DATE >> 5) & 15, 1, 12);
        tf[5] = fit(CUR_DATE & 31, 1, day_limit());
    endtask

    task automatic load_alarm();
        al[0] = fit((CUR_ALARM >> 12) & 31, 0, 23);
        al[1] = fit((CUR_ALARM >> 6) & 63, 0, 59);
        al[2] = fit(CUR_ALARM & 63, 0, 59);
    endtask

    // Advance the model by one clock edge
    task automatic model(input bit rst_n, input bit m, input bit n, input bit u, input bit d);
        int dir;
        dir = u ? 1 : -1;
        e_setting = 0;
        e_aset = 0;
        if (!rst_n) begin
            mode = M_IDLE; sel = 0;
            tf[0] = 0; tf[1] = 0; tf[2] = 0; tf[3] = 16; tf[4] = 1; tf[5] = 1;
            al[0] = 0; al[1] = 0; al[2] = 0;
        end else begin
            case (mode)
                M_IDLE: if (m) begin mode = M_TIME; sel = 0; load_time(); end
                M_TIME: begin
                    if (m) begin
                        mode = M_ALARM; sel = 0; load_time(); load_alarm();
                    end else if (n) begin
                        if (sel == 5) begin mode = M_COMMIT; e_setting = 1; sel = 0; end
                        else sel++;
                    end else if (u || d) begin
                        tf[sel] = wrap(tf[sel], lo_of(sel), hi_of(sel), dir);
`ifdef TIME_SET_MONTH_LEN_EN
                        if ((sel == 3 || sel == 4) && tf[5] > mlen(tf[4], tf[3])) tf[5] = mlen(tf[4], tf[3]);
`endif
                    end
                end
                M_ALARM: begin
                    if (m) begin
                        mode = M_IDLE; sel = 0;
                    end else if (n) begin
                        if (sel == 2) begin mode = M_COMMIT; e_aset = 1; sel = 0; end
                        else sel++;
                    end else if (u || d) begin
                        al[sel] = wrap(al[sel], lo_of(sel), hi_of(sel), dir);
                    end
                end
                default: mode = M_IDLE;
            endcase
        end
        if (mode == M_TIME || mode == M_ALARM) begin
            bcnt++;
            e_blink = (bcnt / DIV) % 2;
        end else begin
            bcnt = 0;
            e_blink = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int et;
        et = (tf[0] >= 12 ? (1 << 17) : 0) + tf[0] * 4096 + tf[1] * 64 + tf[2];
        chk("set_time", 32'(SET_TIME), et);
        chk("set_date", 32'(SET_DATE), tf[3] * 512 + tf[4] * 32 + tf[5]);
        chk("set_alarm", 32'(SET_ALARM), al[0] * 4096 + al[1] * 64 + al[2]);
        chk("setting", 32'(SETTING), e_setting);
        chk("alarm_set", 32'(ALARM_SET), e_aset);
        chk("edit_active", 32'(EDIT_ACTIVE), (mode == M_TIME || mode == M_ALARM) ? 1 : 0);
        chk("field_sel", 32'(FIELD_SEL), sel);
        chk("blink", 32'(BLINK), e_blink);
    endtask

    // One clock: drive buttons, let the edge happen, update model, compare
    task automatic step(input bit rst_n, input bit m, input bit n, input bit u, input bit d);
        RESETN = rst_n; BTN_MODE = m; BTN_NEXT = n; BTN_UP = u; BTN_DOWN = d;
        @(posedge CLK);
        model(rst_n, m, n, u, d);
        #1;
        BTN_MODE = 1'b0; BTN_NEXT = 1'b0; BTN_UP = 1'b0; BTN_DOWN = 1'b0;
        check_all();
    endtask

    task automatic set_cur(input int h, input int mi, input int s, input int y, input int mo,
                           input int dd, input int ah, input int am, input int as_);
        CUR_TIME  = 18'(h * 4096 + mi * 64 + s);
        CUR_DATE  = 16'(y * 512 + mo * 32 + dd);
        CUR_ALARM = 17'(ah * 4096 + am * 64 + as_);
    endtask

    initial begin
        // Reset values
        set_cur(0, 34, 56, 23, 7, 15, 7, 30, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_date_const", 32'(SET_DATE), 32'(16 * 512 + 1 * 32 + 1));
        chk("rst_time_const", 32'(SET_TIME), 32'd0);
        step(1, 0, 0, 0, 0);

        // Time commit: MODE, UP x3, NEXT x6
        step(1, 1, 0, 0, 0);
        repeat (3) step(1, 0, 0, 1, 0);
        repeat (6) step(1, 0, 1, 0, 0);
        chk("commit_strobe", 32'(SETTING), 32'd1);
        chk("commit_hour", 32'(SET_TIME[16:12]), 32'd3);
        chk("commit_min", 32'(SET_TIME[11:6]), 32'd34);
        chk("commit_date", 32'(SET_DATE), 32'(23 * 512 + 7 * 32 + 15));
        step(1, 0, 0, 0, 0);
        chk("strobe_one_cycle", 32'(SETTING), 32'd0);

        // Wrap-around at field limits
        set_cur(23, 0, 0, 0, 12, 10, 7, 30, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        chk("wrap_hour", 32'(SET_TIME[16:12]), 32'd0);
        chk("meridian_am", 32'(SET_TIME[17]), 32'd0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1);
        chk("wrap_min", 32'(SET_TIME[11:6]), 32'd59);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1);
        chk("wrap_year", 32'(SET_DATE[15:9]), 32'd99);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0);
        chk("wrap_month", 32'(SET_DATE[8:5]), 32'd1);
        // Abort through MODE x2 more (three in total), then idle without strobe
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("abort_idle", 32'(EDIT_ACTIVE), 32'd0);

        // Alarm commit: MODE, MODE, UP, NEXT x3
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        repeat (3) step(1, 0, 1, 0, 0);
        chk("alarm_strobe", 32'(ALARM_SET), 32'd1);
        chk("alarm_hour", 32'(SET_ALARM[16:12]), 32'd8);
        chk("alarm_no_setting", 32'(SETTING), 32'd0);
        step(1, 0, 0, 0, 0);

        // UP and DOWN together: increment only; also blink over a few periods
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 1, 1);
        chk("updown_prio", 32'(SET_TIME[11:6]), 32'd1);
        repeat (2 * DIV + 3) step(1, 0, 0, 0, 0);

        // Reset during EDIT_TIME
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("midrst_time", 32'(SET_TIME), 32'd0);
        chk("midrst_edit", 32'(EDIT_ACTIVE), 32'd0);
        step(1, 0, 0, 0, 0);
        chk("midrst_nostrobe", 32'(SETTING), 32'd0);

        // Month length: DAY=31, MONTH 1->2
        set_cur(0, 0, 0, 16, 1, 31, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        repeat (4) step(1, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0);
`ifdef TIME_SET_MONTH_LEN_EN
        chk("feb_leap", 32'(SET_DATE[4:0]), 32'd29);
`else
        chk("feb_leap", 32'(SET_DATE[4:0]), 32'd31);
`endif
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        set_cur(0, 0, 0, 17, 1, 31, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        repeat (4) step(1, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0);
`ifdef TIME_SET_MONTH_LEN_EN
        chk("feb_plain", 32'(SET_DATE[4:0]), 32'd28);
`else
        chk("feb_plain", 32'(SET_DATE[4:0]), 32'd31);
`endif
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);

        // Random traffic, including out-of-range snapshots and occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                CUR_TIME  = 18'($urandom);
                CUR_DATE  = 16'($urandom);
                CUR_ALARM = 17'($urandom);
            end
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
